// File: rtl/interleave_addr_counter.sv
// Interleaved address generator: issues {q, lane offset} with a stride of
// 2**OFS_W across one block, then pulses done for a single cycle.
module interleave_addr_counter #(
  parameter int ADDR_W = 13,
  parameter int OFS_W  = 3,
  parameter int SIZE_S = 1056,
  parameter int SIZE_L = 6144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              count_enable,
  input  logic [1:0]        block_mode,
  input  logic [ADDR_W-1:0] cfg_size,
  input  logic [OFS_W-1:0]  offset,
  output logic [ADDR_W-1:0] count,
  output logic              addr_valid,
  output logic              target_reached,
  output logic              done,
  output logic              busy,
  output logic              size_err
);

  localparam int Q_W = ADDR_W - OFS_W;
  localparam logic [ADDR_W:0] STRIDE = (ADDR_W+1)'(2 ** OFS_W);
  localparam logic [ADDR_W:0] TGT_S  = (ADDR_W+1)'(SIZE_S - 1);
  localparam logic [ADDR_W:0] TGT_L  = (ADDR_W+1)'(SIZE_L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [Q_W-1:0]    q_q, q_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic              target_reached_q, target_reached_d;
  logic              size_err_q, size_err_d;

  logic [ADDR_W:0]   sel_target;
  logic [ADDR_W:0]   ofs_ext;
  logic              last;

  assign count          = {q_q, ofs_q};
  assign addr_valid     = (state_q == RUN) && count_enable;
  assign done           = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign target_reached = target_reached_q;
  assign size_err       = size_err_q;

  // Widened by one bit so the stride addition cannot overflow before the compare.
  assign last    = ({1'b0, count} + STRIDE) > target_q;
  assign ofs_ext = {{(ADDR_W+1-OFS_W){1'b0}}, offset};

  always_comb begin
    sel_target = TGT_S;
    unique case (block_mode)
      2'd1:    sel_target = TGT_L;
      2'd2:    sel_target = {1'b0, cfg_size} - {{ADDR_W{1'b0}}, 1'b1};
      default: sel_target = TGT_S;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    q_d              = q_q;
    ofs_d            = ofs_q;
    target_d         = target_q;
    target_reached_d = target_reached_q;
    size_err_d       = size_err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d         = sel_target;
          ofs_d            = offset;
          q_d              = '0;
          target_reached_d = 1'b0;
          size_err_d       = 1'b0;
          state_d          = RUN;
          // A lane offset beyond the block end has nothing to issue.
          if (ofs_ext > sel_target) begin
            size_err_d       = 1'b1;
            target_reached_d = 1'b1;
            state_d          = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (addr_valid) begin
          if (last) begin
            target_reached_d = 1'b1;
            state_d          = DONE;
          end else begin
            q_d = q_q + Q_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (abort) q_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      q_q              <= '0;
      ofs_q            <= '0;
      target_q         <= '0;
      target_reached_q <= 1'b0;
      size_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      q_q              <= q_d;
      ofs_q            <= ofs_d;
      target_q         <= target_d;
      target_reached_q <= target_reached_d;
      size_err_q       <= size_err_d;
    end
  end

endmodule

// File: tb/tb_interleave_addr_counter.sv
// Bench for interleave_addr_counter: vector table, directed block scenarios
// and random traffic checked against an address-list model.
module tb_interleave_addr_counter;

  localparam int ADDR_W = 13;
  localparam int OFS_W  = 3;
  localparam int SIZE_S = 1056;
  localparam int SIZE_L = 6144;
  localparam int STRIDE = 8;

  logic              clk = 1'b0;
  logic              reset, start, abort, count_enable;
  logic [1:0]        block_mode;
  logic [ADDR_W-1:0] cfg_size;
  logic [OFS_W-1:0]  offset;
  logic [ADDR_W-1:0] count;
  logic              addr_valid, target_reached, done, busy, size_err;

  always #5 clk = ~clk;

  interleave_addr_counter #(
    .ADDR_W(ADDR_W), .OFS_W(OFS_W), .SIZE_S(SIZE_S), .SIZE_L(SIZE_L)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .count_enable(count_enable), .block_mode(block_mode), .cfg_size(cfg_size),
    .offset(offset), .count(count), .addr_valid(addr_valid),
    .target_reached(target_reached), .done(done), .busy(busy), .size_err(size_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a block is the list ofs, ofs+8, ... of n addresses; k indexes it.
  int m_phase;  // 0 idle, 1 run, 2 done
  int m_k, m_ofs, m_n;
  bit m_tr, m_serr;

  logic [ADDR_W-1:0] issued[$];
  int n_done_seen;

  typedef struct {
    logic r, s, a, ce;
    logic [1:0] m;
    logic [ADDR_W-1:0] cfg;
    logic [OFS_W-1:0] o;
    logic [ADDR_W-1:0] e_cnt;
    logic e_av, e_tr, e_done, e_busy, e_serr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic r, s, a, ce, input logic [1:0] m,
                              input int cfg, input int o, input int e_cnt,
                              input logic e_av, e_tr, e_done, e_busy, e_serr);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.ce = ce; v.m = m;
    v.cfg = ADDR_W'(cfg); v.o = OFS_W'(o); v.e_cnt = ADDR_W'(e_cnt);
    v.e_av = e_av; v.e_tr = e_tr; v.e_done = e_done; v.e_busy = e_busy; v.e_serr = e_serr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
    end
  endtask

  function automatic void model_next(input logic r, s, a, ce, input logic [1:0] m,
                                     input logic [ADDR_W-1:0] cfg, input logic [OFS_W-1:0] o);
    int len, tgt;
    if (r) begin
      m_phase = 0; m_k = 0; m_ofs = 0; m_n = 0; m_tr = 0; m_serr = 0;
      return;
    end
    case (m_phase)
      0: if (s) begin
        len = (m == 2'd1) ? SIZE_L : (m == 2'd2) ? int'(cfg) : SIZE_S;
        tgt = (len - 1) & ((1 << (ADDR_W + 1)) - 1);
        m_ofs = int'(o);
        m_k = 0;
        if (m_ofs > tgt) begin
          m_serr = 1; m_tr = 1; m_phase = 2;
        end else begin
          m_serr = 0; m_tr = 0; m_phase = 1;
          m_n = (tgt - m_ofs) / STRIDE + 1;
        end
      end
      1: if (a) begin
        m_phase = 0; m_k = 0;
      end else if (ce) begin
        if (m_k == m_n - 1) begin
          m_tr = 1; m_phase = 2;
        end else begin
          m_k++;
        end
      end
      default: begin
        if (a) m_k = 0;
        m_phase = 0;
      end
    endcase
  endfunction

  task automatic drive(input logic r, s, a, ce, input logic [1:0] m,
                       input logic [ADDR_W-1:0] cfg, input logic [OFS_W-1:0] o);
    reset = r; start = s; abort = a; count_enable = ce;
    block_mode = m; cfg_size = cfg; offset = o;
  endtask

  task automatic step(input logic r, s, a, ce, input logic [1:0] m,
                      input logic [ADDR_W-1:0] cfg, input logic [OFS_W-1:0] o,
                      input string nm);
    logic [ADDR_W+4:0] exp_v, act_v;
    drive(r, s, a, ce, m, cfg, o);
    #1;
    exp_v = {ADDR_W'(m_ofs + STRIDE * m_k), (m_phase == 1) && ce, m_tr,
             m_phase == 2, m_phase != 0, m_serr};
    act_v = {count, addr_valid, target_reached, done, busy, size_err};
    chk(nm, 32'(act_v), 32'(exp_v));
    if (addr_valid === 1'b1) issued.push_back(count);
    if (done === 1'b1) n_done_seen++;
    model_next(r, s, a, ce, m, cfg, o);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    logic [ADDR_W+4:0] exp_v, act_v;
    drive(v.r, v.s, v.a, v.ce, v.m, v.cfg, v.o);
    #1;
    exp_v = {v.e_cnt, v.e_av, v.e_tr, v.e_done, v.e_busy, v.e_serr};
    act_v = {count, addr_valid, target_reached, done, busy, size_err};
    chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
    model_next(v.r, v.s, v.a, v.ce, v.m, v.cfg, v.o);
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int limit, input int ce_mode, input string nm);
    n_done_seen = 0;
    for (int c = 0; c < limit && n_done_seen == 0; c++)
      step(0, 0, 0, (ce_mode == 0) ? 1'b1 : ((c % 2) == 0), 2'd0, '0, '0, nm);
    chk({nm, "_done_seen"}, 32'(n_done_seen), 32'd1);
  endtask

  initial begin
    int exp3[5];
    exp3 = '{3, 11, 19, 27, 35};

    drive(1, 0, 0, 0, 2'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_next(1, 0, 0, 0, 2'd0, '0, '0);
    step(1, 0, 0, 1, 2'd0, '0, '0, "reset_state");

    vecs[0]  = mk(0,0,0,0, 2'd0,  0, 0,   0, 0,0,0,0,0);
    vecs[1]  = mk(0,1,0,0, 2'd2, 20, 2,   0, 0,0,0,0,0);
    vecs[2]  = mk(0,0,0,0, 2'd0,  0, 7,   2, 0,0,0,1,0);
    vecs[3]  = mk(0,0,0,1, 2'd0,  0, 7,   2, 1,0,0,1,0);
    vecs[4]  = mk(0,0,0,1, 2'd0,  0, 7,  10, 1,0,0,1,0);
    vecs[5]  = mk(0,0,0,0, 2'd0,  0, 7,  18, 0,0,0,1,0);
    vecs[6]  = mk(0,0,0,1, 2'd0,  0, 7,  18, 1,0,0,1,0);
    vecs[7]  = mk(0,1,0,1, 2'd0,  0, 7,  18, 0,1,1,1,0);
    vecs[8]  = mk(0,0,0,0, 2'd0,  0, 7,  18, 0,1,0,0,0);
    vecs[9]  = mk(0,1,1,0, 2'd2,  2, 5,  18, 0,1,0,0,0);
    vecs[10] = mk(0,0,0,1, 2'd0,  0, 0,   5, 0,1,1,1,1);
    vecs[11] = mk(0,0,0,0, 2'd0,  0, 0,   5, 0,1,0,0,1);
    vecs[12] = mk(0,0,1,0, 2'd0,  0, 0,   5, 0,1,0,0,1);
    vecs[13] = mk(0,1,0,0, 2'd2, 20, 0,   5, 0,1,0,0,1);
    vecs[14] = mk(0,0,0,1, 2'd0,  0, 0,   0, 1,0,0,1,0);
    vecs[15] = mk(0,0,1,1, 2'd0,  0, 0,   8, 1,0,0,1,0);
    vecs[16] = mk(0,0,0,0, 2'd0,  0, 0,   0, 0,0,0,0,0);
    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // Small block, offset 0: 132 addresses ending at 1048.
    issued.delete();
    step(0, 1, 0, 0, 2'd0, '0, 3'd0, "s1_start");
    run_until_done(400, 0, "s1");
    chk("s1_n_addr", 32'(issued.size()), 32'd132);
    chk("s1_first", 32'(issued[0]), 32'd0);
    chk("s1_last", 32'(issued[$]), 32'd1048);
    step(0, 0, 0, 0, 2'd0, '0, '0, "s1_idle");

    // Large block, offset 7: 768 addresses ending at 6143, one done pulse.
    issued.delete();
    step(0, 1, 0, 0, 2'd1, '0, 3'd7, "s2_start");
    run_until_done(1000, 0, "s2");
    step(0, 0, 0, 1, 2'd0, '0, '0, "s2_idle");
    chk("s2_n_addr", 32'(issued.size()), 32'd768);
    chk("s2_first", 32'(issued[0]), 32'd7);
    chk("s2_last", 32'(issued[$]), 32'd6143);
    chk("s2_done_pulses", 32'(n_done_seen), 32'd1);

    // Programmable length 40, offset 3, enable toggling.
    issued.delete();
    step(0, 1, 0, 0, 2'd2, 13'd40, 3'd3, "s3_start");
    run_until_done(100, 1, "s3");
    chk("s3_n_addr", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      chk($sformatf("s3_addr%0d", i), 32'(issued[i]), 32'(exp3[i]));

    // Length 2 with offset 5: immediate size error.
    issued.delete();
    n_done_seen = 0;
    step(0, 1, 0, 1, 2'd2, 13'd2, 3'd5, "s4_start");
    step(0, 0, 0, 1, 2'd0, '0, '0, "s4_done");
    step(0, 0, 0, 1, 2'd0, '0, '0, "s4_idle");
    chk("s4_n_addr", 32'(issued.size()), 32'd0);
    chk("s4_done_pulses", 32'(n_done_seen), 32'd1);

    // Abort after address 80, then a full block.
    issued.delete();
    n_done_seen = 0;
    step(0, 1, 0, 0, 2'd0, '0, 3'd0, "s5_start");
    for (int c = 0; c < 200 && !(issued.size() > 0 && issued[$] == 13'd80); c++)
      step(0, 0, 0, 1, 2'd0, '0, '0, "s5_run");
    chk("s5_reached80", 32'(issued.size()), 32'd11);
    step(0, 0, 1, 0, 2'd0, '0, '0, "s5_abort");
    step(0, 0, 0, 0, 2'd0, '0, '0, "s5_idle");
    chk("s5_no_done", 32'(n_done_seen), 32'd0);
    chk("s5_tr_low", 32'(target_reached), 32'd0);
    issued.delete();
    step(0, 1, 0, 0, 2'd0, '0, 3'd0, "s5_restart");
    run_until_done(400, 0, "s5b");
    chk("s5_full_n_addr", 32'(issued.size()), 32'd132);

    // Reset at address 4000 of a large block, with an ignored mid-run start.
    issued.delete();
    step(0, 0, 0, 0, 2'd0, '0, '0, "s6_pre");
    step(0, 1, 0, 0, 2'd1, '0, 3'd0, "s6_start");
    for (int c = 0; c < 1200 && !(issued.size() > 0 && issued[$] == 13'd4000); c++)
      step(0, (c == 10), 0, 1, 2'd2, 13'd9, 3'd1, "s6_run");
    chk("s6_reached4000", 32'(issued.size()), 32'd501);
    n_done_seen = 0;
    step(1, 0, 0, 1, 2'd0, '0, '0, "s6_reset");
    step(0, 0, 0, 0, 2'd0, '0, '0, "s6_after_reset");
    step(0, 1, 0, 0, 2'd0, '0, 3'd0, "s6_restart");
    step(0, 0, 0, 1, 2'd0, '0, '0, "s6_first");
    chk("s6_first_addr", 32'(issued[$]), 32'd0);
    chk("s6_no_done", 32'(n_done_seen), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int sel;
      logic [1:0] m;
      logic [ADDR_W-1:0] cfg;
      sel = int'($urandom_range(0, 9));
      m = (sel < 5) ? 2'd2 : (sel < 7) ? 2'd0 : (sel < 8) ? 2'd3 : 2'd1;
      cfg = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(1, 8))
                                        : ADDR_W'($urandom_range(1, 300));
      step($urandom_range(0, 599) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
           m, cfg, OFS_W'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
